run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/tinyv_ctrl_pkg.sv | 18 +
 rtl/rst_stagger.sv | 42 ++++
 rtl/run_ctrl.sv | 112 +++++++++++
 tb/tb_run_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/tinyv_ctrl_pkg.sv
// Shared FSM state encoding and default parameter values for the run controller.
// Pure declarations, no logic.
package tinyv_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int DEF_N_CH       = 2;
    localparam int DEF_RST_CYCLES = 2;
    localparam int DEF_STAGGER    = 1;
    localparam int DEF_MAX_CYCLES = 10;
    localparam int DEF_CNT_W      = 32;

endpackage

// File: rtl/rst_stagger.sv
// Staggered per-channel reset release: channel k drops reset after k*STAGGER enabled cycles.
// Registered mask; last is combinational and flags the edge that releases the final channel.
module rst_stagger #(
    parameter int N_CH    = 2,
    parameter int STAGGER = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    output logic [N_CH-1:0] core_rst,
    output logic            last
);

    localparam int REL_MAX = (N_CH - 1) * STAGGER;
    localparam int REL_W   = (REL_MAX > 0) ? $clog2(REL_MAX + 1) : 1;

    logic [REL_W-1:0] rel_cnt;
    logic [N_CH-1:0]  clr;

    always_comb begin
        clr = '0;
        for (int k = 0; k < N_CH; k++) begin
            clr[k] = en && (rel_cnt == REL_W'(k * STAGGER));
        end
    end

    assign last = en && (rel_cnt == REL_W'(REL_MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rel_cnt  <= '0;
            core_rst <= '1;
        end else if (en) begin
            core_rst <= core_rst & ~clr;
            // Counter parks at its final value; it is only used during one release pass.
            if (!last) begin
                rel_cnt <= rel_cnt + REL_W'(1);
            end
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Core run controller: hold all cores in reset, release them staggered, run to all-halted or budget expiry.
// All outputs registered; no backpressure, halt_i is sampled every cycle in RELEASE and RUN.
module run_ctrl
    import tinyv_ctrl_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int STAGGER    = DEF_STAGGER,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  halt_i,
    output logic [N_CH-1:0]  core_rst_o,
    output logic             running_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [N_CH-1:0]  halted_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    if (N_CH < 1)       $error("run_ctrl: N_CH must be >= 1");
    if (RST_CYCLES < 1) $error("run_ctrl: RST_CYCLES must be >= 1");
    if (STAGGER < 0)    $error("run_ctrl: STAGGER must be >= 0");
    if (MAX_CYCLES < 1) $error("run_ctrl: MAX_CYCLES must be >= 1");
    if (CNT_W < 1)      $error("run_ctrl: CNT_W must be >= 1");
    if ((CNT_W < 31) && (MAX_CYCLES >= (1 << CNT_W)))
        $error("run_ctrl: MAX_CYCLES must be < 2**CNT_W");

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [N_CH-1:0]   halted_nxt, seen;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              timeout_nxt;
    logic              rel_en, rel_last;

    assign rel_en = (state == ST_RELEASE);

    rst_stagger #(
        .N_CH    (N_CH),
        .STAGGER (STAGGER)
    ) u_stagger (
        .clk      (clk),
        .reset    (reset),
        .en       (rel_en),
        .core_rst (core_rst_o),
        .last     (rel_last)
    );

    // Halts only count for channels whose core is already out of reset.
    assign seen = halted_o | (halt_i & ~core_rst_o);

    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        halted_nxt  = halted_o;
        cnt_nxt     = cycle_cnt_o;
        timeout_nxt = timeout_o;
        case (state)
            ST_HOLD: begin
                if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
                    state_nxt = ST_RELEASE;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            ST_RELEASE: begin
                halted_nxt = seen;
                if (rel_last) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                halted_nxt = seen;
                // Completion is tested first so a final halt on the last budget cycle is not a timeout.
                if (&seen) begin
                    state_nxt = ST_DONE;
                end else if (cycle_cnt_o == CNT_W'(MAX_CYCLES - 1)) begin
                    state_nxt   = ST_DONE;
                    timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cycle_cnt_o + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_HOLD;
            hold_cnt    <= '0;
            halted_o    <= '0;
            cycle_cnt_o <= '0;
            timeout_o   <= 1'b0;
            running_o   <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            halted_o    <= halted_nxt;
            cycle_cnt_o <= cnt_nxt;
            timeout_o   <= timeout_nxt;
            running_o   <= (state_nxt == ST_RUN);
            done_o      <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: default, 4-channel zero-stagger and 3-channel stagger-2 instances.
module tb_run_ctrl;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instance A: all defaults
    logic        rst_a;
    logic [1:0]  halt_a, crst_a, hlt_a;
    logic        run_a, done_a, to_a;
    logic [31:0] cnt_a;

    run_ctrl u_a (
        .clk(clk), .reset(rst_a), .halt_i(halt_a), .core_rst_o(crst_a),
        .running_o(run_a), .done_o(done_a), .timeout_o(to_a),
        .halted_o(hlt_a), .cycle_cnt_o(cnt_a)
    );

    // Instance B: four channels released together
    logic        rst_b;
    logic [3:0]  halt_b, crst_b, hlt_b;
    logic        run_b, done_b, to_b;
    logic [31:0] cnt_b;

    run_ctrl #(.N_CH(4), .STAGGER(0)) u_b (
        .clk(clk), .reset(rst_b), .halt_i(halt_b), .core_rst_o(crst_b),
        .running_o(run_b), .done_o(done_b), .timeout_o(to_b),
        .halted_o(hlt_b), .cycle_cnt_o(cnt_b)
    );

    // Instance C: three channels, stagger 2, single hold cycle
    logic        rst_c;
    logic [2:0]  halt_c, crst_c, hlt_c;
    logic        run_c, done_c, to_c;
    logic [31:0] cnt_c;

    run_ctrl #(.N_CH(3), .STAGGER(2), .RST_CYCLES(1)) u_c (
        .clk(clk), .reset(rst_c), .halt_i(halt_c), .core_rst_o(crst_c),
        .running_o(run_c), .done_o(done_c), .timeout_o(to_c),
        .halted_o(hlt_c), .cycle_cnt_o(cnt_c)
    );

    task automatic exp_a(input string tag, input logic [1:0] crst, input logic run,
                         input logic dn, input logic to, input logic [1:0] hlt,
                         input logic [31:0] cnt);
        chk({tag, ".core_rst"}, 32'(crst_a), 32'(crst));
        chk({tag, ".running"},  32'(run_a),  32'(run));
        chk({tag, ".done"},     32'(done_a), 32'(dn));
        chk({tag, ".timeout"},  32'(to_a),   32'(to));
        chk({tag, ".halted"},   32'(hlt_a),  32'(hlt));
        chk({tag, ".cycle_cnt"}, cnt_a, cnt);
    endtask

    // Leaves A in RUN with cycle_cnt_o == 0.
    task automatic start_a();
        rst_a  = 1'b1;
        halt_a = 2'b00;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        logic [2:0] seq_c [6];
        seq_c = '{3'b111, 3'b110, 3'b110, 3'b100, 3'b100, 3'b000};

        rst_a = 1'b1; halt_a = '0;
        rst_b = 1'b1; halt_b = 4'b1111;
        rst_c = 1'b1; halt_c = '0;

        // Timeout run with no halts
        #3;
        exp_a("a_rst", 2'b11, 0, 0, 0, 2'b00, 0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        tick(); exp_a("a_hold1", 2'b11, 0, 0, 0, 2'b00, 0);
        tick(); exp_a("a_hold2", 2'b11, 0, 0, 0, 2'b00, 0);
        tick(); exp_a("a_rel0",  2'b10, 0, 0, 0, 2'b00, 0);
        tick(); exp_a("a_run0",  2'b00, 1, 0, 0, 2'b00, 0);
        for (int i = 1; i < 10; i++) begin
            tick();
            chk("a_runcnt", cnt_a, 32'(i));
            chk("a_running", 32'(run_a), 32'd1);
        end
        tick(); exp_a("a_timeout", 2'b00, 0, 1, 1, 2'b00, 9);
        halt_a = 2'b11;
        tick(); tick();
        exp_a("a_frozen", 2'b00, 0, 1, 1, 2'b00, 9);

        // Halts at RUN cycles 3 and 5
        start_a();
        repeat (3) tick();
        halt_a = 2'b01;
        tick();
        chk("a_pulse0.halted", 32'(hlt_a), 32'b01);
        chk("a_pulse0.cnt", cnt_a, 32'd4);
        halt_a = 2'b00;
        tick();
        halt_a = 2'b10;
        tick();
        halt_a = 2'b00;
        exp_a("a_complete", 2'b00, 0, 1, 0, 2'b11, 5);

        // Both halts on the last budget cycle: completion wins
        start_a();
        repeat (9) tick();
        chk("a_last.cnt", cnt_a, 32'd9);
        halt_a = 2'b11;
        tick();
        halt_a = 2'b00;
        exp_a("a_tie", 2'b00, 0, 1, 0, 2'b11, 9);

        // Asynchronous reset mid-run
        start_a();
        repeat (2) tick();
        halt_a = 2'b01;
        tick();
        halt_a = 2'b00;
        tick();
        chk("a_mid.halted", 32'(hlt_a), 32'b01);
        chk("a_mid.cnt", cnt_a, 32'd4);
        #2;
        rst_a = 1'b1;
        #1;
        exp_a("a_async", 2'b11, 0, 0, 0, 2'b00, 0);
        rst_a = 1'b0;
        tick(); exp_a("a_re_hold1", 2'b11, 0, 0, 0, 2'b00, 0);
        tick(); exp_a("a_re_hold2", 2'b11, 0, 0, 0, 2'b00, 0);
        tick(); exp_a("a_re_rel0",  2'b10, 0, 0, 0, 2'b00, 0);
        tick(); exp_a("a_re_run0",  2'b00, 1, 0, 0, 2'b00, 0);

        // Instance B: halts held through hold are ignored, all channels release together
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        tick();
        chk("b_hold.core_rst", 32'(crst_b), 32'b1111);
        chk("b_hold.halted", 32'(hlt_b), 32'b0000);
        tick();
        chk("b_rel.core_rst", 32'(crst_b), 32'b1111);
        chk("b_rel.halted", 32'(hlt_b), 32'b0000);
        tick();
        chk("b_run.core_rst", 32'(crst_b), 32'b0000);
        chk("b_run.halted", 32'(hlt_b), 32'b0000);
        chk("b_run.running", 32'(run_b), 32'd1);
        tick();
        chk("b_done.done", 32'(done_b), 32'd1);
        chk("b_done.timeout", 32'(to_b), 32'd0);
        chk("b_done.halted", 32'(hlt_b), 32'b1111);
        chk("b_done.cnt", cnt_b, 32'd0);

        // Instance C: staggered release; halt on a still-reset channel is dropped
        @(posedge clk);
        #1;
        rst_c = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("c_seq.core_rst", 32'(crst_c), 32'(seq_c[i]));
            if (i == 1) halt_c = 3'b101;
            if (i == 2) begin
                chk("c_rel.halted", 32'(hlt_c), 32'b001);
                halt_c = 3'b000;
            end
        end
        chk("c_run.running", 32'(run_c), 32'd1);
        repeat (10) tick();
        chk("c_end.done", 32'(done_c), 32'd1);
        chk("c_end.timeout", 32'(to_c), 32'd1);
        chk("c_end.halted", 32'(hlt_c), 32'b001);
        chk("c_end.cnt", cnt_c, 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
